hdmi_pixel_reader: RTL

- HDMI-side consumer of the palette-stage pixel FIFO.
- Generates video timing: counters, HSync/VSync/DE.
- Issues one pixelReq pulse per active pixel to pop the FIFO head (hdmiReadData), and drives the registered RGB888 pixel stream to the HDMI encoder.
- Waits for FIFO pre-fill before starting a frame, substitutes a fixed colour on underflow, and counts underflows for the controller.

---
 rtl/hdmi_pixel_reader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_pixel_reader.sv
// hdmi_pixel_reader: video timing generator and pixel-FIFO consumer for
// the HDMI output path, with underflow colour substitution and statistics.
module hdmi_pixel_reader #(
  parameter int          H_ACTIVE        = 1280,
  parameter int          H_FP            = 110,
  parameter int          H_SYNC          = 40,
  parameter int          H_BP            = 220,
  parameter int          V_ACTIVE        = 720,
  parameter int          V_FP            = 5,
  parameter int          V_SYNC          = 5,
  parameter int          V_BP            = 20,
  parameter logic        SYNC_POL        = 1'b1,
  parameter int          CLKS_PER_PIXEL  = 2,
  parameter int          START_LEVEL     = 64,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic        enable,
  input  logic        clearUnderflow,
  input  logic [7:0]  bufferSize,
  input  logic        bufferEmpty,
  input  logic [23:0] hdmiReadData,
  output logic        pixelReq,
  output logic [23:0] hdmiRGB,
  output logic        hdmiDE,
  output logic        hdmiHSync,
  output logic        hdmiVSync,
  output logic [10:0] xPosition,
  output logic [10:0] yPosition,
  output logic        frameStart,
  output logic        underflow,
  output logic [15:0] underflowCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

  localparam logic [10:0]   H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0]   V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0]   HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_PIXEL - 1);
  localparam logic [7:0]    START_L = 8'(START_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [10:0]   hx_q, hx_d;
  logic [10:0]   vy_q, vy_d;

  logic          req_q, req_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [10:0]   xpos_q, xpos_d;
  logic [10:0]   ypos_q, ypos_d;
  logic          fs_q, fs_d;
  logic          uf_q, uf_d;
  logic [15:0]   ucnt_q, ucnt_d;

  logic          slot_edge;
  logic          frame_end;
  logic          run_go;
  logic          active;
  logic          uevent;

  // hx/vy address the next slot; xpos/ypos the one on the wire
  assign slot_edge = (state_q == S_RUN) && (ph_q == '0);
  assign frame_end = slot_edge && (xpos_q == H_LAST)
                     && (ypos_q == V_LAST);
  assign run_go    = (state_q == S_RUN) && (state_d == S_RUN);
  assign active    = (hx_q < H_ACT) && (vy_q < V_ACT);

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      hx_q    <= '0;
      vy_q    <= '0;
      req_q   <= 1'b0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      xpos_q  <= '0;
      ypos_q  <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      hx_q    <= hx_d;
      vy_q    <= vy_d;
      req_q   <= req_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
      ucnt_q  <= ucnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable) state_d = S_IDLE;
        else if (bufferSize >= START_L) state_d = S_RUN;
      end
      S_RUN: begin
        if (frame_end && !enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ph_d = '0;
    hx_d = '0;
    vy_d = '0;
    if (run_go) begin
      if (ph_q == PH_LAST) begin
        vy_d = vy_q;
        if (hx_q == H_LAST) begin
          vy_d = (vy_q == V_LAST) ? '0 : vy_q + 11'd1;
        end else begin
          hx_d = hx_q + 11'd1;
        end
      end else begin
        ph_d = ph_q + PW'(1);
        hx_d = hx_q;
        vy_d = vy_q;
      end
    end
  end

  always_comb begin
    req_d  = 1'b0;
    fs_d   = 1'b0;
    rgb_d  = rgb_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    uevent = 1'b0;

    if (!run_go) begin
      rgb_d  = '0;
      de_d   = 1'b0;
      hs_d   = ~SYNC_POL;
      vs_d   = ~SYNC_POL;
      xpos_d = '0;
      ypos_d = '0;
    end else if (slot_edge) begin
      de_d   = active;
      xpos_d = hx_q;
      ypos_d = vy_q;
      fs_d   = (hx_q == '0) && (vy_q == '0);
      hs_d   = ((hx_q >= HS_BEG) && (hx_q < HS_END)) ?
               SYNC_POL : ~SYNC_POL;
      vs_d   = ((vy_q >= VS_BEG) && (vy_q < VS_END)) ?
               SYNC_POL : ~SYNC_POL;
      unique case (1'b1)
        active && !bufferEmpty: begin
          rgb_d = hdmiReadData;
          req_d = 1'b1;
        end
        active && bufferEmpty: begin
          rgb_d  = UNDERFLOW_COLOR;
          uevent = 1'b1;
        end
        default: rgb_d = '0;
      endcase
    end

    // a clear coinciding with an event leaves that event counted
    uf_d   = uf_q;
    ucnt_d = ucnt_q;
    if (clearUnderflow) begin
      uf_d   = uevent;
      ucnt_d = uevent ? 16'd1 : 16'd0;
    end else if (uevent) begin
      uf_d   = 1'b1;
      ucnt_d = (ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 16'd1;
    end
  end

  assign pixelReq       = req_q;
  assign hdmiRGB        = rgb_q;
  assign hdmiDE         = de_q;
  assign hdmiHSync      = hs_q;
  assign hdmiVSync      = vs_q;
  assign xPosition      = xpos_q;
  assign yPosition      = ypos_q;
  assign frameStart     = fs_q;
  assign underflow      = uf_q;
  assign underflowCount = ucnt_q;

endmodule
